fsm_mini_tx: RTL and testbench

Transmit-side sequencer that drives the `fsm_mini` receiver's `start`/`data_in` interface from a host-side valid/ready byte stream. For each accepted payload byte it emits the start pulse, header byte and payload byte in the cycle order the receiver samples them. It then monitors the receiver's `done`/`data_out` for completion, error code 0xEE or timeout. It reports one response per request through a valid/ready handshake, with optional automatic retry.

---
 rtl/fsm_mini_tx.sv | 200 ++++++++++++++++++++
 tb/tb_fsm_mini_tx.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_mini_tx.sv
// fsm_mini_tx: drives the fsm_mini receiver from a host valid/ready byte stream.
// Optional retry loop is compiled in when FSM_MINI_TX_RETRY_EN is defined.
module fsm_mini_tx #(
    parameter int TIMEOUT_W = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_data,
    output logic       resp_err,
    output logic       resp_timeout,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_HDR,
        S_PAY,
        S_WAIT,
        S_REC,
        S_RESP
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           pay_q, pay_d;
    logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;
    logic [TIMEOUT_W-1:0] to_inc;
    logic                 rec_q, rec_d;
    logic                 cause_err_q, cause_err_d;
    logic                 cause_to_q, cause_to_d;
    logic [7:0]           rdata_q, rdata_d;
    logic                 rerr_q, rerr_d;
    logic                 rto_q, rto_d;
    logic                 rdy_q, rdy_d;
    logic                 accept;
    logic                 retry_ok;

    assign accept = (state_q == S_IDLE) && in_valid && rdy_q;

`ifdef FSM_MINI_TX_RETRY_EN
    localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

    logic [2:0] retry_q, retry_d;

    // retry counter: cleared per request, bumped on each loop back to START
    always_ff @(posedge clk) begin
        if (rst) begin
            retry_q <= 3'd0;
        end else begin
            retry_q <= retry_d;
        end
    end

    // retry counter next value, saturating at MAX_RETRY
    always_comb begin
        retry_d = retry_q;
        if (accept) begin
            retry_d = 3'd0;
        end else if (state_q == S_REC && rec_q && retry_q < MAX_R) begin
            retry_d = retry_q + 3'd1;
        end
    end

    assign retry_ok = (retry_q < MAX_R);
`else
    logic unused_max_retry;

    assign retry_ok         = 1'b0;
    assign unused_max_retry = (MAX_RETRY != 0);
`endif

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pay_q       <= 8'h00;
            to_cnt_q    <= '0;
            rec_q       <= 1'b0;
            cause_err_q <= 1'b0;
            cause_to_q  <= 1'b0;
            rdata_q     <= 8'h00;
            rerr_q      <= 1'b0;
            rto_q       <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pay_q       <= pay_d;
            to_cnt_q    <= to_cnt_d;
            rec_q       <= rec_d;
            cause_err_q <= cause_err_d;
            cause_to_q  <= cause_to_d;
            rdata_q     <= rdata_d;
            rerr_q      <= rerr_d;
            rto_q       <= rto_d;
            rdy_q       <= rdy_d;
        end
    end

    // next-state, counters and response capture
    always_comb begin
        state_d     = state_q;
        pay_d       = pay_q;
        to_cnt_d    = to_cnt_q;
        rec_d       = 1'b0;
        cause_err_d = cause_err_q;
        cause_to_d  = cause_to_q;
        rdata_d     = rdata_q;
        rerr_d      = rerr_q;
        rto_d       = rto_q;
        to_inc      = to_cnt_q + TIMEOUT_W'(1);

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    pay_d       = in_data;
                    to_cnt_d    = '0;
                    cause_err_d = 1'b0;
                    cause_to_d  = 1'b0;
                    rdata_d     = 8'h00;
                    rerr_d      = 1'b0;
                    rto_d       = 1'b0;
                    state_d     = S_START;
                end
            end
            S_START: state_d = S_HDR;
            S_HDR:   state_d = S_PAY;
            S_PAY: begin
                to_cnt_d = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                to_cnt_d = to_inc;
                if (rx_done) begin
                    rdata_d = rx_data;
                    rerr_d  = 1'b0;
                    rto_d   = 1'b0;
                    state_d = S_RESP;
                end else if (rx_data == 8'hEE) begin
                    cause_err_d = 1'b1;
                    cause_to_d  = 1'b0;
                    state_d     = S_REC;
                end else if (to_inc == '1) begin
                    cause_err_d = 1'b0;
                    cause_to_d  = 1'b1;
                    state_d     = S_REC;
                end
            end
            S_REC: begin
                if (!rec_q) begin
                    rec_d = 1'b1;
                end else if (retry_ok) begin
                    state_d = S_START;
                end else begin
                    rdata_d = 8'h00;
                    rerr_d  = cause_err_q;
                    rto_d   = cause_to_q;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rdy_d = (state_d == S_IDLE);
    end

    // receiver-side drive decoded from state only
    always_comb begin
        tx_data = 8'h00;
        unique case (state_q)
            S_HDR:         tx_data = 8'h01;
            S_PAY, S_WAIT: tx_data = pay_q;
            S_REC:         tx_data = 8'h07;
            default:       tx_data = 8'h00;
        endcase
    end

    assign tx_start     = (state_q == S_START);
    assign in_ready     = rdy_q;
    assign resp_valid   = (state_q == S_RESP);
    assign resp_data    = rdata_q;
    assign resp_err     = rerr_q;
    assign resp_timeout = rto_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_fsm_mini_tx.sv
// tb_fsm_mini_tx: randomized bench checked against a transaction-level model.
// Model follows the build's retry setting (FSM_MINI_TX_RETRY_EN).
module tb_fsm_mini_tx;

    localparam int TW     = 4;
    localparam int MR     = 2;
    localparam int TO_CYC = (1 << TW) - 1;
`ifdef FSM_MINI_TX_RETRY_EN
    localparam int N_ATT  = MR + 1;
`else
    localparam int N_ATT  = 1;
`endif
    localparam int K_DONE = 0;
    localparam int K_EE   = 1;
    localparam int K_TO   = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_data;
    logic       resp_err;
    logic       resp_timeout;
    logic       busy;

    always #5 clk = ~clk;

    fsm_mini_tx #(
        .TIMEOUT_W(TW),
        .MAX_RETRY(MR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data(resp_data),
        .resp_err(resp_err),
        .resp_timeout(resp_timeout),
        .busy(busy)
    );

    typedef struct {
        bit         st;
        int         dat;
        bit         rv;
        bit         dn;
        logic [7:0] rxd;
        bit         rr;
        logic [7:0] rd;
        bit         re;
        bit         rt;
    } cyc_t;

    cyc_t       q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         kd[8];
    int         kw[8];
    logic [7:0] kv[8];
    logic [7:0] pay_g;
    int         bp_g;
    bit         hold_g;
    int         rst_off_g;
    int         wait0_idx;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] no_ee();
        logic [7:0] v;
        v = 8'($urandom);
        if (v == 8'hEE) v = 8'h11;
        return v;
    endfunction

    task automatic push(input bit st, input int dat, input bit rv,
                        input bit dn, input logic [7:0] rxd, input bit rr,
                        input logic [7:0] rd, input bit re, input bit rt);
        cyc_t c;
        c.st  = st;
        c.dat = dat;
        c.rv  = rv;
        c.dn  = dn;
        c.rxd = rxd;
        c.rr  = rr;
        c.rd  = rd;
        c.re  = re;
        c.rt  = rt;
        q.push_back(c);
    endtask

    // Expected per-cycle trace after the accept cycle, from the protocol rules.
    task automatic build();
        int         nw;
        bit         dn;
        bit         fin;
        logic [7:0] v;
        logic [7:0] rd;
        bit         re;
        bit         rt;
        q.delete();
        wait0_idx = -1;
        fin = 1'b0;
        rd  = 8'h00;
        re  = 1'b0;
        rt  = 1'b0;
        for (int a = 0; a < N_ATT && !fin; a++) begin
            push(1'b1, 0, 1'b0, 1'($urandom), 8'($urandom), 1'b0, 0, 0, 0);
            push(1'b0, 1, 1'b0, 1'($urandom), 8'($urandom), 1'b0, 0, 0, 0);
            push(1'b0, int'(pay_g), 1'b0, 1'($urandom), 8'($urandom),
                 1'b0, 0, 0, 0);
            nw = (kd[a] == K_TO) ? TO_CYC : kw[a] + 1;
            if (a == 0) wait0_idx = q.size();
            for (int w = 0; w < nw; w++) begin
                dn = 1'b0;
                v  = no_ee();
                if (w == kw[a] && kd[a] == K_DONE) begin
                    dn = 1'b1;
                    v  = kv[a];
                end
                if (w == kw[a] && kd[a] == K_EE) v = 8'hEE;
                push(1'b0, int'(pay_g), 1'b0, dn, v, 1'b0, 0, 0, 0);
            end
            if (kd[a] == K_DONE) begin
                fin = 1'b1;
                rd  = kv[a];
                re  = 1'b0;
                rt  = 1'b0;
            end else begin
                for (int r = 0; r < 2; r++)
                    push(1'b0, 7, 1'b0, 1'($urandom), 8'($urandom),
                         1'b0, 0, 0, 0);
                rd = 8'h00;
                re = (kd[a] == K_EE);
                rt = (kd[a] == K_TO);
            end
        end
        for (int b = 0; b <= bp_g; b++)
            push(1'b0, -1, 1'b1, 1'($urandom), 8'($urandom),
                 (b == bp_g), rd, re, rt);
    endtask

    task automatic chk_reset();
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_data", 32'(resp_data), 0);
        chk("rst_resp_err", 32'(resp_err), 0);
        chk("rst_resp_timeout", 32'(resp_timeout), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
    endtask

    // Entered and left in an IDLE cycle, just after its falling edge.
    task automatic run_txn();
        int rst_idx;
        build();
        rst_idx = (rst_off_g >= 0) ? wait0_idx + rst_off_g : -1;
        chk("idle_in_ready", 32'(in_ready), 1);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_resp_valid", 32'(resp_valid), 0);
        in_valid   = 1'b1;
        in_data    = pay_g;
        rx_done    = 1'($urandom);
        rx_data    = 8'($urandom);
        resp_ready = 1'($urandom);
        for (int e = 0; e < q.size(); e++) begin
            @(negedge clk);
            chk("tx_start", 32'(tx_start), 32'(q[e].st));
            if (q[e].dat >= 0)
                chk("tx_data", 32'(tx_data), 32'(q[e].dat));
            chk("busy", 32'(busy), 1);
            chk("in_ready", 32'(in_ready), 0);
            chk("resp_valid", 32'(resp_valid), 32'(q[e].rv));
            if (q[e].rv) begin
                chk("resp_data", 32'(resp_data), 32'(q[e].rd));
                chk("resp_err", 32'(resp_err), 32'(q[e].re));
                chk("resp_timeout", 32'(resp_timeout), 32'(q[e].rt));
            end
            rx_done    = q[e].dn;
            rx_data    = q[e].rxd;
            resp_ready = q[e].rr;
            in_valid   = (q[e].rv && hold_g) ? 1'b1 : 1'($urandom);
            in_data    = 8'($urandom);
            if (e == rst_idx) begin
                rst      = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                chk_reset();
                rst = 1'b0;
                @(negedge clk);
                return;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            chk("gap_in_ready", 32'(in_ready), 1);
            chk("gap_busy", 32'(busy), 0);
            chk("gap_resp_valid", 32'(resp_valid), 0);
            chk("gap_tx_start", 32'(tx_start), 0);
            in_valid   = 1'b0;
            in_data    = 8'($urandom);
            rx_done    = 1'($urandom);
            rx_data    = 8'($urandom);
            resp_ready = 1'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic plan(input logic [7:0] p, input int bp, input bit hold,
                        input int roff);
        pay_g     = p;
        bp_g      = bp;
        hold_g    = hold;
        rst_off_g = roff;
        for (int a = 0; a < 8; a++) begin
            kd[a] = K_TO;
            kw[a] = 0;
            kv[a] = 8'h00;
        end
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        rx_done    = 1'b0;
        rx_data    = 8'h00;
        resp_ready = 1'b0;
        @(negedge clk);
        chk_reset();
        @(negedge clk);
        chk_reset();
        rst = 1'b0;
        @(negedge clk);

        // normal: done with 0x55 on the 3rd WAIT cycle
        plan(8'h0B, 0, 1'b0, -1);
        kd[0] = K_DONE; kw[0] = 2; kv[0] = 8'h55;
        run_txn();
        idle(1);

        // 0xEE in the first attempt, done with 0x22 in the second
        plan(8'h3C, 1, 1'b0, -1);
        kd[0] = K_EE; kw[0] = 1;
        kd[1] = K_DONE; kw[1] = 0; kv[1] = 8'h22;
        run_txn();
        idle(2);

        // no done at all: every attempt times out
        plan(8'h5A, 0, 1'b0, -1);
        run_txn();
        idle(1);

        // backpressure with in_valid held, then immediate next request
        plan(8'h81, 5, 1'b1, -1);
        kd[0] = K_DONE; kw[0] = 0; kv[0] = 8'hA5;
        run_txn();
        plan(8'h42, 0, 1'b0, -1);
        kd[0] = K_DONE; kw[0] = 4; kv[0] = 8'h99;
        run_txn();
        idle(1);

        // reset pulse in the middle of WAIT
        plan(8'h77, 0, 1'b0, 3);
        kd[0] = K_DONE; kw[0] = 10; kv[0] = 8'h12;
        run_txn();
        idle(3);

        // done together with 0xEE on the timeout cycle: done wins
        plan(8'h19, 0, 1'b0, -1);
        kd[0] = K_DONE; kw[0] = TO_CYC - 1; kv[0] = 8'hEE;
        run_txn();
        idle(1);

        // 0xEE on the timeout cycle: error cause, not timeout
        plan(8'h2D, 0, 1'b0, -1);
        for (int a = 0; a < 8; a++) begin
            kd[a] = K_EE;
            kw[a] = TO_CYC - 1;
        end
        run_txn();
        idle(1);

        for (int t = 0; t < 40; t++) begin
            int nw0;
            plan(8'($urandom), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), -1);
            for (int a = 0; a < 8; a++) begin
                kd[a] = $urandom_range(0, 2);
                kw[a] = $urandom_range(0, TO_CYC - 1);
                kv[a] = ($urandom_range(0, 3) == 0) ? 8'hEE : 8'($urandom);
            end
            nw0 = (kd[0] == K_TO) ? TO_CYC : kw[0] + 1;
            if ($urandom_range(0, 9) == 0)
                rst_off_g = $urandom_range(0, nw0 - 1);
            run_txn();
            if (!hold_g || rst_off_g >= 0) idle($urandom_range(0, 2));
        end

        idle(1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
